// File: rtl/step_seq_pkg.sv
// Shared types and constants for the BPF step sequencer.
// Step indices name the phases of the default five-step instruction.
package step_seq_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int BPF_NSTEPS = 5;

   localparam int FETCH  = 0;
   localparam int DECODE = 1;
   localparam int EXEC   = 2;
   localparam int MEM    = 3;
   localparam int WB     = 4;

endpackage

// File: rtl/step_seq_if.sv
// Control/status bundle between the step sequencer and the datapath control.
// No valid/ready handshake: inputs are levels sampled on every rising edge; outputs are registered levels, except oDONE, which is a one-cycle pulse.
interface step_seq_if
   import step_seq_pkg::*;
#(
   parameter int NSTEPS = BPF_NSTEPS,
   parameter int CNTW   = 32
) ();

   localparam int IDXW = $clog2(NSTEPS);

   logic              iEN;
   logic              iSTALL;
   logic              iLAST;
   logic              iFLUSH;
   logic [NSTEPS-1:0] oSTEP;
   logic [IDXW-1:0]   oIDX;
   logic              oBUSY;
   logic              oDONE;
   logic [CNTW-1:0]   oICNT;
   state_t            oSTATE;

   modport master (
      output iEN, iSTALL, iLAST, iFLUSH,
      input  oSTEP, oIDX, oBUSY, oDONE, oICNT, oSTATE
   );

   modport slave (
      input  iEN, iSTALL, iLAST, iFLUSH,
      output oSTEP, oIDX, oBUSY, oDONE, oICNT, oSTATE
   );

endinterface

// File: rtl/step_seq.sv
// Multi-cycle one-hot step sequencer gating the BPF core phases.
// IDLE/RUN FSM with stall, early end, flush, retire pulse and retired count.
module step_seq
   import step_seq_pkg::*;
#(
   parameter int NSTEPS = BPF_NSTEPS,
   parameter int IDXW   = $clog2(NSTEPS),
   parameter int CNTW   = 32
) (
   input logic       iCLK,
   input logic       iRST,
   step_seq_if.slave bus
);

   localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(NSTEPS - 1);
   localparam logic [NSTEPS-1:0] STEP0    = NSTEPS'(1);

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [NSTEPS-1:0] step_q, step_d;
   logic              done_q, done_d;
   logic [CNTW-1:0]   icnt_q, icnt_d;
   logic              instr_end;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         step_q  <= '0;
         done_q  <= 1'b0;
         icnt_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         step_q  <= step_d;
         done_q  <= done_d;
         icnt_q  <= icnt_d;
      end
   end

   // Flush beats stall beats instruction end; iEN only matters at a boundary.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      icnt_d    = icnt_q;
      instr_end = bus.iLAST || (idx_q == LAST_IDX);
      if (state_q == ST_IDLE) begin
         if (bus.iEN) begin
            state_d = ST_RUN;
            idx_d   = '0;
         end
      end else if (bus.iFLUSH) begin
         idx_d   = '0;
         state_d = bus.iEN ? ST_RUN : ST_IDLE;
      end else if (bus.iSTALL) begin
         idx_d = idx_q;
      end else if (instr_end) begin
         done_d  = 1'b1;
         icnt_d  = icnt_q + 1'b1;
         idx_d   = '0;
         state_d = bus.iEN ? ST_RUN : ST_IDLE;
      end else begin
         idx_d = idx_q + 1'b1;
      end
      // One-hot is registered alongside the index so the strobes are glitch-free.
      step_d = (state_d == ST_RUN) ? (STEP0 << idx_d) : '0;
   end

   always_comb begin
      bus.oSTEP  = step_q;
      bus.oIDX   = idx_q;
      bus.oBUSY  = (state_q == ST_RUN);
      bus.oDONE  = done_q;
      bus.oICNT  = icnt_q;
      bus.oSTATE = state_q;
   end

endmodule

// File: tb/tb_step_seq.sv
// Bench for step_seq: reference model feeds an expected queue checked after every edge,
// plus scenario tasks with directed checks and parameter-variant instances.
module tb_step_seq;
   import step_seq_pkg::*;

   localparam int N  = 5;
   localparam int IW = $clog2(N);
   localparam int CW = 32;
   localparam int W  = N + IW + 2 + CW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   step_seq_if #(.NSTEPS(N),  .CNTW(CW)) bus   ();
   step_seq_if #(.NSTEPS(2),  .CNTW(4))  bus2  ();
   step_seq_if #(.NSTEPS(16), .CNTW(CW)) bus16 ();

   step_seq #(.NSTEPS(N),  .CNTW(CW)) dut   (.iCLK(clk), .iRST(rst), .bus(bus));
   step_seq #(.NSTEPS(2),  .CNTW(4))  dut2  (.iCLK(clk), .iRST(rst), .bus(bus2));
   step_seq #(.NSTEPS(16), .CNTW(CW)) dut16 (.iCLK(clk), .iRST(rst), .bus(bus16));

   int pass_cnt = 0;
   int chk_cnt  = 0;

   bit            m_run  = 1'b0;
   int            m_idx  = 0;
   logic [CW-1:0] m_icnt = '0;
   bit            m_done = 1'b0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] sb_exp, sb_act;

   function automatic logic [W-1:0] pack_out(logic [N-1:0] s, logic [IW-1:0] i,
                                             logic b, logic d, logic [CW-1:0] c);
      return {s, i, b, d, c};
   endfunction

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         sb_exp = exp_q.pop_front();
         sb_act = pack_out(bus.oSTEP, bus.oIDX, bus.oBUSY, bus.oDONE, bus.oICNT);
         chk_cnt++;
         if (sb_act !== sb_exp)
            $display("FAIL scoreboard t=%0t: got step/idx/busy/done/cnt=%h required %h",
                     $time, sb_act, sb_exp);
         else
            pass_cnt++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   // Apply one cycle of inputs, advance the model, queue the expected outputs.
   task automatic drive(input logic en, input logic st, input logic la, input logic fl);
      logic [N-1:0] s;
      bus.iEN = en; bus.iSTALL = st; bus.iLAST = la; bus.iFLUSH = fl;
      m_done = 1'b0;
      if (!m_run) begin
         if (en) begin m_run = 1'b1; m_idx = 0; end
      end else if (fl) begin
         m_idx = 0; m_run = en;
      end else if (!st) begin
         if (la || m_idx == N - 1) begin
            m_done = 1'b1; m_icnt = m_icnt + 1'b1; m_idx = 0; m_run = en;
         end else begin
            m_idx = m_idx + 1;
         end
      end
      s = '0;
      if (m_run) s[m_idx] = 1'b1;
      exp_q.push_back(pack_out(s, IW'(m_idx), m_run, m_done, m_icnt));
      @(posedge clk); #2;
   endtask

   task automatic goto_idx(input int t);
      int k;
      k = 0;
      while (!(bus.oBUSY === 1'b1 && bus.oIDX == IW'(t)) && k < 20) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0);
         k++;
      end
      chk_cnt++;
      if (k >= 20) $display("FAIL goto_idx: never reached idx %0d, at %0d", t, bus.oIDX);
      else pass_cnt++;
   endtask

   task automatic reset_dut;
      rst = 1'b1;
      bus.iEN = 0;  bus.iSTALL = 0;  bus.iLAST = 0;  bus.iFLUSH = 0;
      bus2.iEN = 0; bus16.iEN = 0;
      repeat (2) @(posedge clk);
      #2; rst = 1'b0;
      m_run = 1'b0; m_idx = 0; m_icnt = '0; m_done = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.iEN = 1; bus.iSTALL = 0; bus.iLAST = 0; bus.iFLUSH = 0;
      bus2.iEN = 0; bus2.iSTALL = 0; bus2.iLAST = 0; bus2.iFLUSH = 0;
      bus16.iEN = 0; bus16.iSTALL = 0; bus16.iLAST = 0; bus16.iFLUSH = 0;
      repeat (2) @(posedge clk);
      #2;
      chk_cnt++;
      if ({bus.oSTEP, bus.oIDX, bus.oBUSY, bus.oDONE, bus.oICNT} !== '0)
         $display("FAIL reset_outputs: got %h required 0",
                  {bus.oSTEP, bus.oIDX, bus.oBUSY, bus.oDONE, bus.oICNT});
      else pass_cnt++;
      chk_cnt++;
      if (bus.oSTATE !== ST_IDLE) $display("FAIL reset_state: got %0d required IDLE", bus.oSTATE);
      else pass_cnt++;
      rst = 1'b0;
      m_run = 1'b0; m_idx = 0; m_icnt = '0; m_done = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_free_run;
      logic [4:0] seq [5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
      logic exp_done;
      for (int c = 1; c <= 12; c++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0);
         exp_done = (c == 6 || c == 11);
         chk_cnt++;
         if (bus.oSTEP !== seq[(c - 1) % 5])
            $display("FAIL free_run_step c=%0d: got %b required %b", c, bus.oSTEP, seq[(c - 1) % 5]);
         else pass_cnt++;
         chk_cnt++;
         if (bus.oDONE !== exp_done)
            $display("FAIL free_run_done c=%0d: got %b required %b", c, bus.oDONE, exp_done);
         else pass_cnt++;
      end
      chk_cnt++;
      if (bus.oICNT !== 32'd2) $display("FAIL free_run_icnt: got %0d required 2", bus.oICNT);
      else pass_cnt++;
   endtask

   task automatic test_stall;
      int n, stalls;
      logic [CW-1:0] c0;
      goto_idx(0);
      c0 = bus.oICNT; n = 0; stalls = 0;
      do begin
         if (bus.oIDX == 3'd2 && stalls < 3) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            stalls++;
            chk_cnt++;
            if (bus.oSTEP !== 5'b00100) $display("FAIL stall_hold: got %b required 00100", bus.oSTEP);
            else pass_cnt++;
         end else begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
         end
         n++;
      end while (bus.oDONE !== 1'b1 && n < 20);
      chk_cnt++;
      if (n != 8) $display("FAIL stall_length: got %0d cycles required 8", n);
      else pass_cnt++;
      chk_cnt++;
      if (bus.oICNT !== c0 + 1) $display("FAIL stall_icnt: got %0d required %0d", bus.oICNT, c0 + 1);
      else pass_cnt++;
   endtask

   task automatic test_early_flush;
      logic [CW-1:0] c0;
      goto_idx(1);
      c0 = bus.oICNT;
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      chk_cnt++;
      if ({bus.oIDX, bus.oDONE, bus.oICNT} !== {3'd0, 1'b1, c0 + 32'd1})
         $display("FAIL early_end: got idx=%0d done=%b cnt=%0d required 0 1 %0d",
                  bus.oIDX, bus.oDONE, bus.oICNT, c0 + 1);
      else pass_cnt++;

      goto_idx(3);
      c0 = bus.oICNT;
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      chk_cnt++;
      if ({bus.oIDX, bus.oDONE, bus.oICNT} !== {3'd0, 1'b0, c0})
         $display("FAIL flush: got idx=%0d done=%b cnt=%0d required 0 0 %0d",
                  bus.oIDX, bus.oDONE, bus.oICNT, c0);
      else pass_cnt++;

      goto_idx(2);
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      chk_cnt++;
      if (bus.oSTEP !== 5'b00001) $display("FAIL flush_over_stall: got %b required 00001", bus.oSTEP);
      else pass_cnt++;

      goto_idx(2);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk_cnt++;
      if ({bus.oBUSY, bus.oSTEP} !== 6'b0) $display("FAIL flush_to_idle: got busy=%b step=%b required 0", bus.oBUSY, bus.oSTEP);
      else pass_cnt++;
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      chk_cnt++;
      if ({bus.oBUSY, bus.oDONE} !== 2'b0) $display("FAIL idle_ignores: got busy=%b done=%b required 0 0", bus.oBUSY, bus.oDONE);
      else pass_cnt++;
   endtask

   task automatic test_enable_drop;
      goto_idx(1);
      for (int k = 2; k <= 4; k++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0);
         chk_cnt++;
         if (bus.oIDX !== IW'(k) || bus.oBUSY !== 1'b1)
            $display("FAIL en_drop_step: got idx=%0d busy=%b required %0d 1", bus.oIDX, bus.oBUSY, k);
         else pass_cnt++;
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk_cnt++;
      if ({bus.oDONE, bus.oBUSY, bus.oSTEP} !== 7'b1_0_00000)
         $display("FAIL en_drop_end: got done=%b busy=%b step=%b required 1 0 0", bus.oDONE, bus.oBUSY, bus.oSTEP);
      else pass_cnt++;
      repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk_cnt++;
      if (bus.oBUSY !== 1'b0) $display("FAIL en_drop_idle: got busy=%b required 0", bus.oBUSY);
      else pass_cnt++;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk_cnt++;
      if ({bus.oBUSY, bus.oSTEP} !== 6'b1_00001) $display("FAIL restart: got busy=%b step=%b required 1 00001", bus.oBUSY, bus.oSTEP);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      logic [CW-1:0] c0;
      goto_idx(0);
      c0 = bus.oICNT;
      for (int k = 1; k <= 6; k++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0);
         chk_cnt++;
         if ({bus.oDONE, bus.oIDX, bus.oICNT} !== {1'b1, 3'd0, c0 + CW'(k)})
            $display("FAIL back_to_back k=%0d: got done=%b idx=%0d cnt=%0d required 1 0 %0d",
                     k, bus.oDONE, bus.oIDX, bus.oICNT, c0 + CW'(k));
         else pass_cnt++;
      end
   endtask

   task automatic test_random;
      logic en, st, la, fl;
      for (int k = 0; k < 80; k++) begin
         en = ($urandom_range(0, 7) != 0);
         st = ($urandom_range(0, 3) == 0);
         la = ($urandom_range(0, 5) == 0);
         fl = ($urandom_range(0, 9) == 0);
         drive(en, st, la, fl);
         if (bus.oBUSY === 1'b1) begin
            chk_cnt++;
            if (bus.oSTEP !== (5'b00001 << bus.oIDX) || bus.oIDX > 3'd4)
               $display("FAIL onehot_invariant: got step=%b idx=%0d", bus.oSTEP, bus.oIDX);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_async_reset;
      reset_dut();
      repeat (39) drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk_cnt++;
      if (bus.oIDX !== 3'd3 || bus.oICNT !== 32'd7)
         $display("FAIL async_pre: got idx=%0d cnt=%0d required 3 7", bus.oIDX, bus.oICNT);
      else pass_cnt++;
      rst = 1'b1;
      #1;
      chk_cnt++;
      if ({bus.oSTEP, bus.oIDX, bus.oBUSY, bus.oDONE, bus.oICNT} !== '0)
         $display("FAIL async_reset: got %h required 0",
                  {bus.oSTEP, bus.oIDX, bus.oBUSY, bus.oDONE, bus.oICNT});
      else pass_cnt++;
   endtask

   task automatic test_params;
      int max16, done2;
      reset_dut();
      bus2.iEN = 1'b1; bus16.iEN = 1'b1;
      max16 = 0; done2 = 0;
      for (int c = 1; c <= 35; c++) begin
         @(posedge clk); #2;
         chk_cnt++;
         if (bus2.oIDX !== 1'((c - 1) % 2) || bus2.oSTEP !== (2'b01 << ((c - 1) % 2)))
            $display("FAIL n2_step c=%0d: got idx=%0d step=%b", c, bus2.oIDX, bus2.oSTEP);
         else pass_cnt++;
         chk_cnt++;
         if (bus16.oIDX !== 4'((c - 1) % 16) || bus16.oSTEP !== (16'h0001 << ((c - 1) % 16)))
            $display("FAIL n16_step c=%0d: got idx=%0d step=%h", c, bus16.oIDX, bus16.oSTEP);
         else pass_cnt++;
         if (int'(bus16.oIDX) > max16) max16 = int'(bus16.oIDX);
         if (bus2.oDONE === 1'b1) done2++;
      end
      chk_cnt++;
      if (done2 != 17) $display("FAIL n2_retires: got %0d required 17", done2);
      else pass_cnt++;
      chk_cnt++;
      if (bus2.oICNT !== 4'd1) $display("FAIL cnt_wrap: got %0d required 1", bus2.oICNT);
      else pass_cnt++;
      chk_cnt++;
      if (max16 != 15 || bus16.oICNT !== 32'd2)
         $display("FAIL n16_period: got max_idx=%0d cnt=%0d required 15 2", max16, bus16.oICNT);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_stall();
      test_early_flush();
      test_enable_drop();
      test_back_to_back();
      test_random();
      test_async_reset();
      test_params();
      repeat (2) @(posedge clk);
      #2;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
